gol_generation_ctrl: RTL and testbench
======================================

// Module: gol_generation_ctrl
// PURPOSE
//  Owns the live 16x16 Game of Life board and sits directly upstream of the combinational next-generation
//  stage: drives it with cur_board, commits its next_board on each generation step, and accumulates its
//  per-generation birth/death counts. Also provides serial seed loading and a registered row read-out.
// PARAMETERS
//  ROWS      16        board rows (row index width = $clog2(ROWS))
//  COLS      16        board columns (row data width)
//  TICK_DIV  25000000  clk cycles between auto-steps while run=1 (>=SETTLE_CYC+2)
//  SETTLE_CYC 4        cycles cur_board is held stable before next_board is sampled (>=1)
//  CNT_W     32        width of gen_cnt, total_births, total_deaths
// PORTS
//  clk            in   1          system clock, rising edge
//  rst_n          in   1          synchronous reset, active low
//  run            in   1          level: auto-step every TICK_DIV cycles
//  step_req       in   1          pulse: request one generation (honoured in IDLE only)
//  clear          in   1          pulse: zero board, counters, extinct
//  load_valid     in   1          seed row write strobe
//  load_ready     out  1          1 when a load beat is accepted (state IDLE)
//  load_row_idx   in   log2(ROWS) row to write
//  load_row_data  in   COLS       row contents, bit j = column j
//  cur_board      out  ROWS*COLS  flattened live board, cell (i,j) at bit i*COLS+j
//  next_board     in   ROWS*COLS  next generation from algorithm stage, same packing
//  birth_cnt_in   in   9          births in next_board vs cur_board (0..256)
//  death_cnt_in   in   9          deaths in next_board vs cur_board (0..256)
//  rd_row_idx     in   log2(ROWS) display read address
//  rd_row_data    out  COLS       row rd_row_idx, registered, 1-cycle latency
//  gen_tick       out  1          1-cycle pulse on each commit
//  gen_cnt        out  CNT_W      generations committed since reset/clear
//  total_births   out  CNT_W      saturating sum of birth_cnt_in at commits
//  total_deaths   out  CNT_W      saturating sum of death_cnt_in at commits
//  extinct        out  1          sticky: last commit produced an all-zero board
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; board, rd_row_data, gen_cnt, totals, tick counter = 0;
//    gen_tick=0, extinct=0; load_ready=1 after the reset edge.
//  - States: IDLE -> SETTLE -> COMMIT -> IDLE. load_ready = (state==IDLE).
//  - IDLE priority per cycle: clear > load_valid > step trigger. Losers that cycle are dropped, not queued.
//  - clear (any state): next cycle board=0, counters=0, extinct=0, tick counter=0, state=IDLE.
//  - Load: in IDLE with load_valid, row load_row_idx <= load_row_data next edge; extinct cleared;
//    idx >= ROWS ignored. load_valid outside IDLE ignored.
//  - Step trigger = step_req | (run & ~extinct & tick_cnt==TICK_DIV-1). tick_cnt counts 0..TICK_DIV-1
//    only while run=1 and state==IDLE; held otherwise; reset to 0 on trigger, clear, or run=0.
//  - SETTLE: cur_board unchanged for SETTLE_CYC cycles, then COMMIT.
//  - COMMIT (1 cycle): board <= next_board; gen_cnt+1 (wraps); totals += counts, saturating at all-ones;
//    extinct <= (next_board==0); gen_tick=1 this cycle only; -> IDLE. Step-to-commit latency =
//    SETTLE_CYC+1 cycles after trigger edge; new board visible on cur_board the cycle after COMMIT.
//  - extinct=1 blocks auto-step; step_req still honoured (commits a zero board, counts add 0).
//  - rd_row_data <= board[rd_row_idx] every cycle (idx >= ROWS -> 0); reflects commit/load one edge later.
//  - Reset mid-SETTLE/COMMIT aborts: no commit, all state per reset.
// STRUCTURE
//  - Shared package gol_pkg: GOL_ROWS, GOL_COLS, GOL_CELLS, GOL_CNT_IN_W=9, state enum
//    {GS_IDLE, GS_SETTLE, GS_COMMIT}, cell-index function idx(i,j)=i*COLS+j.
//  - One sub-module: gol_tick_timer (TICK_DIV counter with enable/clear, emits tick pulse).
//  - Board storage is a flat register, not RAM (whole board read in parallel by algorithm stage).
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> cur_board=0, gen_cnt=0, load_ready=1, gen_tick=0, extinct=0.
//  2 Blinker: load row7=16'h0070, step_req; model next_board -> after SETTLE_CYC+1 cycles gen_tick=1,
//    cur_board row6/7/8 bit5 set, gen_cnt=1, births=2, deaths=2; second step restores row7=16'h0070.
//  3 Auto-run with TICK_DIV=10, SETTLE_CYC=4: run=1 for 60 cycles -> gen_tick period exactly 15 cycles.
//  4 Extinction: single cell, step -> board=0, extinct=1, deaths=1; run=1 100 cycles -> no gen_tick;
//    load any row -> extinct=0, auto-steps resume.
//  5 Conflicts: load_valid+step_req same IDLE cycle -> row written, no step; load_valid during SETTLE
//    -> ignored, load_ready=0; clear during SETTLE -> board=0, no gen_tick, state IDLE.
//  6 Saturation/readout: force births 256 per commit with CNT_W=10 -> total_births sticks at 1023;
//    rd_row_idx=3 after load row3=16'hA5A5 -> rd_row_data=16'hA5A5 one cycle later; idx 16 -> 0.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation controller: board geometry,
// controller state encoding and the flat cell-index helper.
package gol_pkg;

    localparam int GOL_ROWS     = 16;
    localparam int GOL_COLS     = 16;
    localparam int GOL_CELLS    = GOL_ROWS * GOL_COLS;
    localparam int GOL_CNT_IN_W = 9;

    typedef enum logic [1:0] {
        GS_IDLE,
        GS_SETTLE,
        GS_COMMIT
    } gol_state_e;

    // Cell (i,j) lives at bit i*cols+j of a flattened board.
    function automatic int idx(input int i, input int j, input int cols = GOL_COLS);
        return i * cols + j;
    endfunction

endpackage

// File: rtl/gol_tick_timer.sv
// Free-running divider for the auto-step cadence: counts 0..TICK_DIV-1 while
// enabled, holds when disabled, and flags the last count as a tick.
module gol_tick_timer #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (i_en) begin
            w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_tick = i_en & (r_cnt == LAST);

endmodule

// File: rtl/gol_generation_ctrl.sv
// Owns the live Game of Life board: feeds the next-generation stage, commits its
// result after a settle window, accumulates statistics and serves seed load / row read-out.
module gol_generation_ctrl
    import gol_pkg::*;
#(
    parameter  int ROWS       = GOL_ROWS,
    parameter  int COLS       = GOL_COLS,
    parameter  int TICK_DIV   = 25000000,
    parameter  int SETTLE_CYC = 4,
    parameter  int CNT_W      = 32,
    localparam int RIDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    step_req,
    input  logic                    clear,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [RIDX_W-1:0]       load_row_idx,
    input  logic [COLS-1:0]         load_row_data,
    output logic [ROWS*COLS-1:0]    cur_board,
    input  logic [ROWS*COLS-1:0]    next_board,
    input  logic [GOL_CNT_IN_W-1:0] birth_cnt_in,
    input  logic [GOL_CNT_IN_W-1:0] death_cnt_in,
    input  logic [RIDX_W-1:0]       rd_row_idx,
    output logic [COLS-1:0]         rd_row_data,
    output logic                    gen_tick,
    output logic [CNT_W-1:0]        gen_cnt,
    output logic [CNT_W-1:0]        total_births,
    output logic [CNT_W-1:0]        total_deaths,
    output logic                    extinct
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam int SUM_W = ((CNT_W > GOL_CNT_IN_W) ? CNT_W : GOL_CNT_IN_W) + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [GOL_CNT_IN_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    gol_state_e              r_state;
    gol_state_e              w_state_next;
    logic [SET_W-1:0]        r_settle;
    logic [SET_W-1:0]        w_settle_next;
    logic [ROWS*COLS-1:0]    r_board;
    logic [ROWS*COLS-1:0]    w_board_next;
    logic [COLS-1:0]         r_rd_row;
    logic [COLS-1:0]         w_rd_row;
    logic [CNT_W-1:0]        r_gen_cnt;
    logic [CNT_W-1:0]        r_births;
    logic [CNT_W-1:0]        r_deaths;
    logic                    r_extinct;

    logic                    w_idle;
    logic                    w_tick;
    logic                    w_trigger;
    logic                    w_load_acc;
    logic                    w_go;
    logic                    w_commit;
    logic [COLS-1:0]         w_rows [ROWS];
    logic [ROWS-1:0]         w_row_we;

    assign w_idle     = (r_state == GS_IDLE);
    assign w_trigger  = step_req | (run & ~r_extinct & w_tick);
    assign w_load_acc = w_idle & load_valid & ~clear;
    assign w_go       = w_idle & ~clear & ~load_valid & w_trigger;
    // A clear landing on the commit cycle wins: nothing is committed or reported.
    assign w_commit   = (r_state == GS_COMMIT) & ~clear;

    gol_tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (run & w_idle),
        .i_clr  (clear | ~run | (w_idle & w_trigger)),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        if (clear) begin
            w_state_next  = GS_IDLE;
            w_settle_next = '0;
        end else begin
            case (r_state)
                GS_IDLE: begin
                    if (w_go) begin
                        w_state_next  = GS_SETTLE;
                        w_settle_next = '0;
                    end
                end
                GS_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        w_state_next = GS_COMMIT;
                    end else begin
                        w_settle_next = r_settle + SET_W'(1);
                    end
                end
                GS_COMMIT: begin
                    w_state_next = GS_IDLE;
                end
                default: begin
                    w_state_next = GS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= GS_IDLE;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= w_settle_next;
        end
    end

    // Row-sliced board update; out-of-range load indices match no row.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign w_rows[gi]   = r_board[gi*COLS +: COLS];
            assign w_row_we[gi] = w_load_acc & (int'(load_row_idx) == gi);
            assign w_board_next[gi*COLS +: COLS] =
                clear        ? '0 :
                w_commit     ? next_board[gi*COLS +: COLS] :
                w_row_we[gi] ? load_row_data :
                               w_rows[gi];
        end
    endgenerate

    always_comb begin
        w_rd_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(rd_row_idx) == r) begin
                w_rd_row = w_rows[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_board   <= '0;
            r_rd_row  <= '0;
            r_gen_cnt <= '0;
            r_births  <= '0;
            r_deaths  <= '0;
            r_extinct <= 1'b0;
        end else begin
            r_board  <= w_board_next;
            r_rd_row <= w_rd_row;
            if (clear) begin
                r_gen_cnt <= '0;
                r_births  <= '0;
                r_deaths  <= '0;
                r_extinct <= 1'b0;
            end else if (w_commit) begin
                r_gen_cnt <= r_gen_cnt + CNT_W'(1);
                r_births  <= sat_add(r_births, birth_cnt_in);
                r_deaths  <= sat_add(r_deaths, death_cnt_in);
                r_extinct <= (next_board == '0);
            end else if (w_load_acc) begin
                r_extinct <= 1'b0;
            end
        end
    end

    assign load_ready   = w_idle;
    assign cur_board    = r_board;
    assign rd_row_data  = r_rd_row;
    assign gen_tick     = w_commit;
    assign gen_cnt      = r_gen_cnt;
    assign total_births = r_births;
    assign total_deaths = r_deaths;
    assign extinct      = r_extinct;

endmodule

// File: tb/tb_gol_generation_ctrl.sv
// Scoreboard bench: stimulus predicts each commit (cycle, board, statistics) from a
// Life model; a monitor pops a prediction whenever gen_tick fires.
module tb_gol_generation_ctrl;
    import gol_pkg::*;

    localparam int ROWS       = 16;
    localparam int COLS       = 16;
    localparam int CELLS      = ROWS * COLS;
    localparam int TICK_DIV   = 10;
    localparam int SETTLE_CYC = 4;
    localparam int CNT_W      = 10;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             step_req;
    logic             clear;
    logic             load_valid;
    logic             load_ready;
    logic [3:0]       load_row_idx;
    logic [COLS-1:0]  load_row_data;
    logic [CELLS-1:0] cur_board;
    logic [CELLS-1:0] env_next;
    logic [8:0]       env_birth;
    logic [8:0]       env_death;
    logic [3:0]       rd_row_idx;
    logic [COLS-1:0]  rd_row_data;
    logic             gen_tick;
    logic [CNT_W-1:0] gen_cnt;
    logic [CNT_W-1:0] total_births;
    logic [CNT_W-1:0] total_deaths;
    logic             extinct;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int               cyc;
        logic [CELLS-1:0] board;
        int               gen;
        int               births;
        int               deaths;
        logic             ext;
    } exp_t;
    exp_t exp_q[$];

    logic [CELLS-1:0] m_board;
    int               m_gen;
    int               m_births;
    int               m_deaths;
    logic             m_ext;
    logic             force_births;

    gol_generation_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready), .load_row_idx(load_row_idx),
        .load_row_data(load_row_data), .cur_board(cur_board), .next_board(env_next),
        .birth_cnt_in(env_birth), .death_cnt_in(env_death), .rd_row_idx(rd_row_idx),
        .rd_row_data(rd_row_data), .gen_tick(gen_tick), .gen_cnt(gen_cnt),
        .total_births(total_births), .total_deaths(total_deaths), .extinct(extinct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Conway's rules with dead cells beyond the board edge.
    function automatic logic [CELLS-1:0] life(input logic [CELLS-1:0] b);
        logic [CELLS-1:0] nb;
        int n;
        nb = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                n = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        if (!(di == 0 && dj == 0) && i + di >= 0 && i + di < ROWS &&
                            j + dj >= 0 && j + dj < COLS) begin
                            n += int'(b[idx(i + di, j + dj)]);
                        end
                    end
                end
                nb[idx(i, j)] = (n == 3) || (n == 2 && b[idx(i, j)]);
            end
        end
        return nb;
    endfunction

    // Stand-in for the algorithm stage downstream of cur_board.
    always_comb begin
        env_next  = life(cur_board);
        env_birth = force_births ? 9'd256 : 9'($countones(env_next & ~cur_board));
        env_death = 9'($countones(cur_board & ~env_next));
    end

    task automatic chk(input string nm, input logic [CELLS-1:0] act, input logic [CELLS-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_board = '0; m_gen = 0; m_births = 0; m_deaths = 0; m_ext = 1'b0;
    endtask

    task automatic push_step(input int tick_cyc);
        exp_t e;
        logic [CELLS-1:0] nb;
        int b, d;
        nb = life(m_board);
        b  = force_births ? 256 : $countones(nb & ~m_board);
        d  = $countones(m_board & ~nb);
        m_gen    = (m_gen + 1) & CNT_MAX;
        m_births = (m_births + b > CNT_MAX) ? CNT_MAX : m_births + b;
        m_deaths = (m_deaths + d > CNT_MAX) ? CNT_MAX : m_deaths + d;
        m_ext    = (nb == '0);
        m_board  = nb;
        e.cyc = tick_cyc; e.board = nb; e.gen = m_gen;
        e.births = m_births; e.deaths = m_deaths; e.ext = m_ext;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input int r, input logic [COLS-1:0] d);
        load_valid = 1'b1; load_row_idx = 4'(r); load_row_data = d;
        @(negedge clk);
        load_valid = 1'b0;
        m_board[r*COLS +: COLS] = d;
        m_ext = 1'b0;
        $display("LOAD row=%0d data=%04h", r, d);
    endtask

    task automatic do_step();
        step_req = 1'b1;
        push_step(cyc + 1 + SETTLE_CYC);
        @(negedge clk);
        step_req = 1'b0;
        $display("STEP request at cycle %0d", cyc);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        $display("CLEAR at cycle %0d", cyc);
    endtask

    // Auto-step: first trigger TICK_DIV edges after run rises, then one per full cycle.
    task automatic run_auto(input int n);
        int c;
        c = cyc;
        run = 1'b1;
        for (int t = c + TICK_DIV; t <= c + n; t += TICK_DIV + SETTLE_CYC + 1) begin
            if (m_ext) break;
            push_step(t + SETTLE_CYC);
        end
        repeat (n) @(negedge clk);
        run = 1'b0;
        $display("RUN for %0d cycles ending at cycle %0d", n, cyc);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", CELLS'(exp_q.size()), CELLS'(0));
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        $display("STATE %s gen=%0d births=%0d deaths=%0d extinct=%0b", tag, gen_cnt, total_births, total_deaths, extinct);
        chk({tag, "_board"}, cur_board, m_board);
        chk({tag, "_gen_cnt"}, CELLS'(gen_cnt), CELLS'(m_gen));
        chk({tag, "_births"}, CELLS'(total_births), CELLS'(m_births));
        chk({tag, "_deaths"}, CELLS'(total_deaths), CELLS'(m_deaths));
        chk({tag, "_extinct"}, CELLS'(extinct), CELLS'(m_ext));
        chk({tag, "_load_ready"}, CELLS'(load_ready), CELLS'(1));
    endtask

    task automatic rd_check(input int r);
        rd_row_idx = 4'(r);
        @(negedge clk);
        $display("READ row=%0d data=%04h", r, rd_row_data);
        chk("rd_row_data", CELLS'(rd_row_data), CELLS'(m_board[r*COLS +: COLS]));
    endtask

    initial begin
        logic [CELLS-1:0] exp_b;
        rst_n = 1'b0; run = 1'b0; step_req = 1'b0; clear = 1'b0; load_valid = 1'b0;
        load_row_idx = '0; load_row_data = '0; rd_row_idx = '0; force_births = 1'b0;
        model_reset();

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (gen_tick === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk("gen_tick_unexpected", CELLS'(gen_tick), CELLS'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("gen_tick_cycle", CELLS'(cyc), CELLS'(e.cyc));
                            @(negedge clk);
                            chk("commit_board", cur_board, e.board);
                            chk("commit_gen_cnt", CELLS'(gen_cnt), CELLS'(e.gen));
                            chk("commit_births", CELLS'(total_births), CELLS'(e.births));
                            chk("commit_deaths", CELLS'(total_deaths), CELLS'(e.deaths));
                            chk("commit_extinct", CELLS'(extinct), CELLS'(e.ext));
                            chk("gen_tick_width", CELLS'(gen_tick), CELLS'(0));
                            $display("COMMIT gen=%0d births=%0d deaths=%0d extinct=%0b at cycle %0d",
                                     gen_cnt, total_births, total_deaths, extinct, cyc);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        $display("RESET check at cycle %0d", cyc);
        chk("reset_board", cur_board, '0);
        chk("reset_gen_cnt", CELLS'(gen_cnt), CELLS'(0));
        chk("reset_load_ready", CELLS'(load_ready), CELLS'(1));
        chk("reset_gen_tick", CELLS'(gen_tick), CELLS'(0));
        chk("reset_extinct", CELLS'(extinct), CELLS'(0));
        chk("reset_rd_row", CELLS'(rd_row_data), CELLS'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Blinker
        do_load(7, 16'h0070);
        do_step();
        drain();
        exp_b = '0;
        exp_b[idx(6, 5)] = 1'b1; exp_b[idx(7, 5)] = 1'b1; exp_b[idx(8, 5)] = 1'b1;
        chk("blinker_vertical", cur_board, exp_b);
        chk("blinker_births", CELLS'(total_births), CELLS'(2));
        chk("blinker_deaths", CELLS'(total_deaths), CELLS'(2));
        chk("blinker_gen", CELLS'(gen_cnt), CELLS'(1));
        do_step();
        drain();
        chk("blinker_row7", CELLS'(cur_board[7*COLS +: COLS]), CELLS'(16'h0070));

        // Auto-run cadence
        run_auto(60);
        drain();
        check_state("autorun");

        // Load and step in the same idle cycle: load wins, step dropped
        load_valid = 1'b1; step_req = 1'b1; load_row_idx = 4'd2; load_row_data = 16'h0F00;
        @(negedge clk);
        load_valid = 1'b0; step_req = 1'b0;
        m_board[2*COLS +: COLS] = 16'h0F00; m_ext = 1'b0;
        repeat (12) @(negedge clk);
        check_state("load_vs_step");

        // Load during SETTLE is ignored
        do_step();
        chk("load_ready_settle", CELLS'(load_ready), CELLS'(0));
        load_valid = 1'b1; load_row_idx = 4'd0; load_row_data = 16'hFFFF;
        @(negedge clk);
        load_valid = 1'b0;
        drain();
        check_state("load_in_settle");

        // Clear during SETTLE aborts the step
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        chk("settle_load_ready", CELLS'(load_ready), CELLS'(0));
        do_clear();
        repeat (10) @(negedge clk);
        check_state("clear_in_settle");

        // Reset during SETTLE aborts the step
        do_load(4, 16'h0038);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        check_state("reset_in_settle");

        // Extinction blocks auto-step; a load re-arms it
        do_load(5, 16'h0100);
        do_step();
        drain();
        chk("extinct_set", CELLS'(extinct), CELLS'(1));
        chk("extinct_deaths", CELLS'(total_deaths), CELLS'(1));
        run_auto(100);
        drain();
        do_step();
        drain();
        check_state("extinct_step");
        do_load(2, 16'h000E);
        chk("extinct_cleared", CELLS'(extinct), CELLS'(0));
        run_auto(40);
        drain();
        check_state("extinct_resume");

        // Read-out
        do_load(3, 16'hA5A5);
        rd_row_idx = 4'd3;
        @(negedge clk);
        @(negedge clk);
        chk("rd_row3", CELLS'(rd_row_data), CELLS'(16'hA5A5));
        for (int r = 0; r < 4; r++) rd_check(int'($urandom_range(0, ROWS - 1)));

        // Saturating totals
        force_births = 1'b1;
        repeat (5) begin
            do_step();
            drain();
        end
        force_births = 1'b0;
        chk("births_saturated", CELLS'(total_births), CELLS'(CNT_MAX));
        check_state("saturate");

        // Randomised seeds and steps
        do_clear();
        for (int r = 0; r < ROWS; r++) do_load(r, 16'($urandom));
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) == 0) do_load(int'($urandom_range(0, ROWS - 1)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) run_auto(20);
            else do_step();
            drain();
            check_state("random");
            rd_check(int'($urandom_range(0, ROWS - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
